// File: rtl/ram_port_arbiter_if.sv
// Avalon-MM bundle between the two masters, the RAM port arbiter and the single-port RAM.
// slave = arbiter view, master = view of the masters plus the RAM.
interface ram_port_arbiter_if #(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 32,
  parameter int BE_W   = 4
);
  logic [ADDR_W-1:0] m0_address,    m1_address;
  logic [BE_W-1:0]   m0_byteenable, m1_byteenable;
  logic              m0_read,       m1_read;
  logic              m0_write,      m1_write;
  logic [DATA_W-1:0] m0_writedata,  m1_writedata;
  logic              m0_waitrequest, m1_waitrequest;
  logic [DATA_W-1:0] m0_readdata,    m1_readdata;
  logic              m0_readdatavalid, m1_readdatavalid;
  logic [ADDR_W-1:0] ram_address;
  logic [BE_W-1:0]   ram_byteenable;
  logic              ram_chipselect;
  logic              ram_write;
  logic [DATA_W-1:0] ram_writedata;
  logic [DATA_W-1:0] ram_readdata;

  modport slave (
    input  m0_address, m0_byteenable, m0_read, m0_write, m0_writedata,
    input  m1_address, m1_byteenable, m1_read, m1_write, m1_writedata,
    input  ram_readdata,
    output m0_waitrequest, m0_readdata, m0_readdatavalid,
    output m1_waitrequest, m1_readdata, m1_readdatavalid,
    output ram_address, ram_byteenable, ram_chipselect, ram_write, ram_writedata
  );

  modport master (
    output m0_address, m0_byteenable, m0_read, m0_write, m0_writedata,
    output m1_address, m1_byteenable, m1_read, m1_write, m1_writedata,
    output ram_readdata,
    input  m0_waitrequest, m0_readdata, m0_readdatavalid,
    input  m1_waitrequest, m1_readdata, m1_readdatavalid,
    input  ram_address, ram_byteenable, ram_chipselect, ram_write, ram_writedata
  );
endinterface

// File: rtl/ram_port_arbiter.sv
// Shares a single-port 1-cycle-latency RAM between two Avalon-MM masters (IDLE/ISSUE/RDATA FSM).
// Define RAM_ARB_ROUND_ROBIN_EN for round-robin tie-break; otherwise port 0 has fixed priority.
module ram_port_arbiter #(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 32,
  parameter int BE_W   = 4
) (
  input logic              clk,
  input logic              reset_n,
  ram_port_arbiter_if.slave bus
);
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    RDATA = 2'd2
  } state_e;

  state_e            state_q;
  logic              grant_q;
  logic              grant_d;
`ifdef RAM_ARB_ROUND_ROBIN_EN
  logic              last_grant_q;
`endif
  logic              m0_wait_q, m1_wait_q;
  logic              m0_rvalid_q, m1_rvalid_q;
  logic [DATA_W-1:0] m0_rdata_q, m1_rdata_q;

  logic              m0_req_s, m1_req_s, issue_s;
  logic [ADDR_W-1:0] g_addr_s;
  logic [BE_W-1:0]   g_be_s;
  logic [DATA_W-1:0] g_wdata_s;
  logic              g_write_s;

  assign m0_req_s = bus.m0_read | bus.m0_write;
  assign m1_req_s = bus.m1_read | bus.m1_write;
  assign issue_s  = (state_q == ISSUE);

  // Winner for the next access when the FSM leaves IDLE
  always_comb begin
    grant_d = 1'b0;
    if (m0_req_s && m1_req_s) begin
`ifdef RAM_ARB_ROUND_ROBIN_EN
      grant_d = ~last_grant_q;
`else
      grant_d = 1'b0;
`endif
    end else if (m1_req_s) begin
      grant_d = 1'b1;
    end else begin
      grant_d = 1'b0;
    end
  end

  // Granted port's live request fields; masters hold them stable while stalled
  always_comb begin
    g_addr_s  = {ADDR_W{1'b0}};
    g_be_s    = {BE_W{1'b0}};
    g_wdata_s = {DATA_W{1'b0}};
    g_write_s = 1'b0;
    if (grant_q) begin
      g_addr_s  = bus.m1_address;
      g_be_s    = bus.m1_byteenable;
      g_wdata_s = bus.m1_writedata;
      g_write_s = bus.m1_write;
    end else begin
      g_addr_s  = bus.m0_address;
      g_be_s    = bus.m0_byteenable;
      g_wdata_s = bus.m0_writedata;
      g_write_s = bus.m0_write;
    end
  end

  // reset_n gating keeps the RAM untouched in any reset cycle
  assign bus.ram_chipselect   = issue_s & reset_n;
  assign bus.ram_write        = issue_s & reset_n & g_write_s;
  assign bus.ram_address      = issue_s ? g_addr_s  : {ADDR_W{1'b0}};
  assign bus.ram_byteenable   = issue_s ? g_be_s    : {BE_W{1'b0}};
  assign bus.ram_writedata    = issue_s ? g_wdata_s : {DATA_W{1'b0}};

  assign bus.m0_waitrequest   = m0_wait_q;
  assign bus.m1_waitrequest   = m1_wait_q;
  assign bus.m0_readdata      = m0_rdata_q;
  assign bus.m1_readdata      = m1_rdata_q;
  assign bus.m0_readdatavalid = m0_rvalid_q;
  assign bus.m1_readdatavalid = m1_rvalid_q;

  // Arbitration FSM with registered waitrequest/readdata/readdatavalid
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q      <= IDLE;
      grant_q      <= 1'b0;
`ifdef RAM_ARB_ROUND_ROBIN_EN
      last_grant_q <= 1'b1;
`endif
      m0_wait_q    <= 1'b1;
      m1_wait_q    <= 1'b1;
      m0_rvalid_q  <= 1'b0;
      m1_rvalid_q  <= 1'b0;
      m0_rdata_q   <= {DATA_W{1'b0}};
      m1_rdata_q   <= {DATA_W{1'b0}};
    end else begin
      m0_rvalid_q <= 1'b0;
      m1_rvalid_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (m0_req_s || m1_req_s) begin
            state_q      <= ISSUE;
            grant_q      <= grant_d;
`ifdef RAM_ARB_ROUND_ROBIN_EN
            last_grant_q <= grant_d;
`endif
            m0_wait_q    <= grant_d;
            m1_wait_q    <= ~grant_d;
          end else begin
            state_q   <= IDLE;
            m0_wait_q <= 1'b1;
            m1_wait_q <= 1'b1;
          end
        end
        ISSUE: begin
          m0_wait_q <= 1'b1;
          m1_wait_q <= 1'b1;
          state_q   <= g_write_s ? IDLE : RDATA;
        end
        RDATA: begin
          if (grant_q) begin
            m1_rdata_q  <= bus.ram_readdata;
            m1_rvalid_q <= 1'b1;
          end else begin
            m0_rdata_q  <= bus.ram_readdata;
            m0_rvalid_q <= 1'b1;
          end
          state_q <= IDLE;
        end
        default: begin
          state_q   <= IDLE;
          m0_wait_q <= 1'b1;
          m1_wait_q <= 1'b1;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_ram_port_arbiter.sv
// Directed bench for ram_port_arbiter: RAM model, cycle-timed transaction model, per-cycle compare.
module tb_ram_port_arbiter;
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  ram_port_arbiter_if #(.ADDR_W(10), .DATA_W(32), .BE_W(4)) bus ();

  ram_port_arbiter #(.ADDR_W(10), .DATA_W(32), .BE_W(4)) dut (
    .clk(clk), .reset_n(reset_n), .bus(bus)
  );

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // RAM: registered address, unregistered data out
  logic [31:0] ram_mem [0:1023];
  logic [9:0]  ram_addr_q;
  always @(posedge clk) begin
    if (bus.ram_chipselect) begin
      for (int b = 0; b < 4; b++)
        if (bus.ram_write && bus.ram_byteenable[b])
          ram_mem[bus.ram_address][8*b +: 8] <= bus.ram_writedata[8*b +: 8];
      ram_addr_q <= bus.ram_address;
    end
  end
  assign bus.ram_readdata = ram_mem[ram_addr_q];

  function automatic logic req_of(input int p);
    return (p == 1) ? (bus.m1_read | bus.m1_write) : (bus.m0_read | bus.m0_write);
  endfunction
  function automatic logic wait_of(input int p);
    return (p == 1) ? bus.m1_waitrequest : bus.m0_waitrequest;
  endfunction
  function automatic logic valid_of(input int p);
    return (p == 1) ? bus.m1_readdatavalid : bus.m0_readdatavalid;
  endfunction
  function automatic logic [31:0] rdata_of(input int p);
    return (p == 1) ? bus.m1_readdata : bus.m0_readdata;
  endfunction

  task automatic set_port(input int p, input logic rd, input logic wr, input logic [9:0] a,
                          input logic [3:0] be, input logic [31:0] wd);
    if (p == 1) begin
      bus.m1_read = rd; bus.m1_write = wr; bus.m1_address = a;
      bus.m1_byteenable = be; bus.m1_writedata = wd;
    end else begin
      bus.m0_read = rd; bus.m0_write = wr; bus.m0_address = a;
      bus.m0_byteenable = be; bus.m0_writedata = wd;
    end
  endtask

  // Transaction model: an access granted from an idle cycle T is accepted at T+1;
  // a write frees the RAM at T+2, a read returns data with a valid pulse at T+3.
  int          cyc = 0;
  int          free_at = 0;
  int          acc_cyc = -10;
  int          val_cyc = -10;
  int          acc_port = 0;
  int          val_port = 0;
  int          w = 0;
`ifdef RAM_ARB_ROUND_ROBIN_EN
  int          lastg = 1;
`endif
  logic        acc_wr = 1'b0;
  logic [9:0]  acc_addr = 10'h0;
  logic [3:0]  acc_be = 4'h0;
  logic [31:0] acc_wd = 32'h0;
  logic [9:0]  val_addr = 10'h0;
  logic [31:0] mdl_mem [0:1023];
  logic        exp_wait [2];
  logic        exp_val [2];
  logic [31:0] exp_rd [2];
  logic        exp_cs, exp_wr;
  logic [9:0]  exp_addr;
  logic [3:0]  exp_be;
  logic [31:0] exp_wd;

  initial begin : model
    forever begin
      @(posedge clk);
      cyc = cyc + 1;
      if (reset_n && acc_cyc == cyc - 1 && acc_wr)
        for (int b = 0; b < 4; b++)
          if (acc_be[b]) mdl_mem[acc_addr][8*b +: 8] = acc_wd[8*b +: 8];
      exp_wait[0] = 1'b1; exp_wait[1] = 1'b1; exp_val[0] = 1'b0; exp_val[1] = 1'b0;
      exp_cs = 1'b0; exp_wr = 1'b0; exp_addr = 10'h0; exp_be = 4'h0; exp_wd = 32'h0;
      if (!reset_n) begin
        free_at = cyc; acc_cyc = -10; val_cyc = -10;
        exp_rd[0] = 32'h0; exp_rd[1] = 32'h0;
`ifdef RAM_ARB_ROUND_ROBIN_EN
        lastg = 1;
`endif
      end else begin
        if (cyc == val_cyc) begin
          exp_val[val_port] = 1'b1;
          exp_rd[val_port]  = mdl_mem[val_addr];
        end
        if (cyc - 1 >= free_at && (req_of(0) || req_of(1))) begin
          if (req_of(0) && req_of(1)) begin
`ifdef RAM_ARB_ROUND_ROBIN_EN
            w = 1 - lastg;
`else
            w = 0;
`endif
          end else begin
            w = req_of(1) ? 1 : 0;
          end
`ifdef RAM_ARB_ROUND_ROBIN_EN
          lastg = w;
`endif
          acc_cyc  = cyc;
          acc_port = w;
          acc_wr   = (w == 1) ? bus.m1_write : bus.m0_write;
          acc_addr = (w == 1) ? bus.m1_address : bus.m0_address;
          acc_be   = (w == 1) ? bus.m1_byteenable : bus.m0_byteenable;
          acc_wd   = (w == 1) ? bus.m1_writedata : bus.m0_writedata;
          if (acc_wr) begin
            free_at = cyc + 1;
          end else begin
            free_at  = cyc + 2;
            val_cyc  = cyc + 2;
            val_port = w;
            val_addr = acc_addr;
          end
        end
        if (acc_cyc == cyc) begin
          exp_wait[acc_port] = 1'b0;
          exp_cs = 1'b1; exp_wr = acc_wr; exp_addr = acc_addr; exp_be = acc_be; exp_wd = acc_wd;
        end
      end
    end
  end

  // Every-cycle comparison of all DUT outputs against the model
  initial begin : compare
    @(posedge clk);
    forever begin
      @(negedge clk);
      chk("m0_waitrequest", bus.m0_waitrequest, exp_wait[0]);
      chk("m1_waitrequest", bus.m1_waitrequest, exp_wait[1]);
      chk("m0_readdatavalid", bus.m0_readdatavalid, exp_val[0]);
      chk("m1_readdatavalid", bus.m1_readdatavalid, exp_val[1]);
      chk("m0_readdata", bus.m0_readdata, exp_rd[0]);
      chk("m1_readdata", bus.m1_readdata, exp_rd[1]);
      chk("ram_chipselect", bus.ram_chipselect, exp_cs & reset_n);
      chk("ram_write", bus.ram_write, exp_wr & reset_n);
      chk("ram_address", bus.ram_address, exp_addr);
      chk("ram_byteenable", bus.ram_byteenable, exp_be);
      chk("ram_writedata", bus.ram_writedata, exp_wd);
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: bench did not finish, got timeout, expected completion");
    $fatal(1, "timeout");
  end

  // Called at posedge+#1; latencies are counted in cycles from the request cycle
  task automatic do_access(input int p, input logic rd, input logic wr, input logic [9:0] a,
                           input logic [3:0] be, input logic [31:0] wd,
                           output int acc_lat, output int val_lat, output logic [31:0] rdata);
    acc_lat = -1; val_lat = -1; rdata = 32'h0;
    set_port(p, rd, wr, a, be, wd);
    for (int n = 0; n < 16; n++) begin
      @(negedge clk);
      if (!wait_of(p)) begin acc_lat = n; break; end
    end
    @(posedge clk); #1;
    set_port(p, 1'b0, 1'b0, 10'h0, 4'h0, 32'h0);
    if (rd && !wr && acc_lat >= 0) begin
      for (int n = acc_lat + 1; n < acc_lat + 16; n++) begin
        @(negedge clk);
        if (valid_of(p)) begin val_lat = n; rdata = rdata_of(p); break; end
      end
    end
  endtask

  int          al, vl, nv, n1v;
  logic [31:0] rd;
  int          gq [$];

  initial begin : stim
    set_port(0, 1'b0, 1'b0, 10'h0, 4'h0, 32'h0);
    set_port(1, 1'b0, 1'b0, 10'h0, 4'h0, 32'h0);

    // Reset held for several cycles
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_m0_wait", bus.m0_waitrequest, 32'd1);
    chk("rst_m1_wait", bus.m1_waitrequest, 32'd1);
    chk("rst_m0_valid", bus.m0_readdatavalid, 32'd0);
    chk("rst_m1_valid", bus.m1_readdatavalid, 32'd0);
    chk("rst_cs", bus.ram_chipselect, 32'd0);
    chk("rst_m0_rdata", bus.m0_readdata, 32'h0);
    chk("rst_m1_rdata", bus.m1_readdata, 32'h0);
    @(posedge clk); #1;
    reset_n = 1'b1;

    // Single write then read at the top address
    @(posedge clk); #1;
    do_access(0, 1'b0, 1'b1, 10'h3FF, 4'hF, 32'hDEADBEEF, al, vl, rd);
    chk("wr_accept_lat", al, 32'd1);
    @(posedge clk); #1;
    do_access(0, 1'b1, 1'b0, 10'h3FF, 4'hF, 32'h0, al, vl, rd);
    chk("rd_accept_lat", al, 32'd1);
    chk("rd_valid_lat", vl, 32'd3);
    chk("rd_data_3ff", rd, 32'hDEADBEEF);
    chk("m1_rdata_untouched", bus.m1_readdata, 32'h0);

    // Byte lanes
    @(posedge clk); #1;
    do_access(0, 1'b0, 1'b1, 10'h020, 4'hF, 32'h11223344, al, vl, rd);
    @(posedge clk); #1;
    do_access(0, 1'b0, 1'b1, 10'h020, 4'h5, 32'hAABBCCDD, al, vl, rd);
    @(posedge clk); #1;
    do_access(0, 1'b1, 1'b0, 10'h020, 4'hF, 32'h0, al, vl, rd);
    chk("byte_lane_data", rd, 32'h11BB33DD);

    // Contention: preload, then both ports read continuously
    @(posedge clk); #1;
    do_access(0, 1'b0, 1'b1, 10'h001, 4'hF, 32'hC0C00001, al, vl, rd);
    @(posedge clk); #1;
    do_access(1, 1'b0, 1'b1, 10'h002, 4'hF, 32'hC1C10002, al, vl, rd);
    @(posedge clk); #1;
    set_port(0, 1'b1, 1'b0, 10'h001, 4'hF, 32'h0);
    set_port(1, 1'b1, 1'b0, 10'h002, 4'hF, 32'h0);
    nv = 0;
    for (int n = 0; n < 13; n++) begin
      if (n == 11) begin
        @(posedge clk); #1;
        set_port(0, 1'b0, 1'b0, 10'h0, 4'h0, 32'h0);
        set_port(1, 1'b0, 1'b0, 10'h0, 4'h0, 32'h0);
      end
      @(negedge clk);
      if (!bus.m0_waitrequest) gq.push_back(0);
      if (!bus.m1_waitrequest) gq.push_back(1);
      if (bus.m0_readdatavalid) begin nv++; chk("cont_m0_data", bus.m0_readdata, 32'hC0C00001); end
      if (bus.m1_readdatavalid) begin nv++; chk("cont_m1_data", bus.m1_readdata, 32'hC1C10002); end
    end
    chk("cont_grant_count", gq.size(), 32'd4);
    chk("cont_valid_count", nv, 32'd4);
    for (int i = 0; i < 4; i++) begin
      if (i < gq.size()) begin
`ifdef RAM_ARB_ROUND_ROBIN_EN
        chk("cont_grant_rr", gq[i], i % 2);
`else
        chk("cont_grant_fixed", gq[i], 32'd0);
`endif
      end
    end

    // Reset asserted during the RDATA cycle of a read
    @(posedge clk); #1;
    set_port(0, 1'b1, 1'b0, 10'h3FF, 4'hF, 32'h0);
    @(negedge clk);
    @(negedge clk);
    chk("rst_mid_accept", bus.m0_waitrequest, 32'd0);
    @(posedge clk); #1;
    set_port(0, 1'b0, 1'b0, 10'h0, 4'h0, 32'h0);
    reset_n = 1'b0;
    @(negedge clk);
    @(posedge clk); #1;
    reset_n = 1'b1;
    for (int n = 0; n < 2; n++) begin
      @(negedge clk);
      chk("rst_mid_m0_valid", bus.m0_readdatavalid, 32'd0);
      chk("rst_mid_m1_valid", bus.m1_readdatavalid, 32'd0);
      chk("rst_mid_ram_write", bus.ram_write, 32'd0);
    end
    @(posedge clk); #1;
    do_access(0, 1'b0, 1'b1, 10'h030, 4'hF, 32'h0BADF00D, al, vl, rd);
    chk("post_rst_accept_lat", al, 32'd1);

    // Read and write together on m1: behaves as a write
    @(posedge clk); #1;
    do_access(1, 1'b1, 1'b1, 10'h010, 4'hF, 32'h5A5A5A5A, al, vl, rd);
    chk("rdwr_accept_lat", al, 32'd1);
    n1v = 0;
    for (int n = 0; n < 4; n++) begin
      @(negedge clk);
      if (bus.m1_readdatavalid || bus.m0_readdatavalid) n1v++;
    end
    chk("rdwr_no_valid", n1v, 32'd0);
    @(posedge clk); #1;
    do_access(1, 1'b1, 1'b0, 10'h010, 4'hF, 32'h0, al, vl, rd);
    chk("rdwr_readback_lat", vl, 32'd3);
    chk("rdwr_readback", rd, 32'h5A5A5A5A);

    repeat (3) @(posedge clk);
    @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/ram_port_arbiter.md
# ram_port_arbiter

Two-port arbiter that shares the single-port 1024×32 on-chip RAM between two Avalon-MM masters: port 0 for the Nios data master and port 1 for the alarm/display refresh engine. It sits between the masters and the RAM slave. It serialises accesses through a small FSM, stalls the losing master with `waitrequest`, and returns read data with a registered `readdatavalid` pulse. The RAM has a one-cycle read latency: address is registered and the output is unregistered.

## Interface
Parameters:
- `ADDR_W`, 10, word address width (1024 words)
- `DATA_W`, 32, data width
- `BE_W`, 4, byte-enable width (`DATA_W/8`)

Ports:
- `clk`, in, 1, single clock for the block and the RAM
- `reset_n`, in, 1, reset, synchronous and active-low
- `m0_address` / `m1_address`, in, `ADDR_W`, word address per master
- `m0_byteenable` / `m1_byteenable`, in, `BE_W`, byte lanes for writes
- `m0_read` / `m1_read`, in, 1, read request, held until accepted
- `m0_write` / `m1_write`, in, 1, write request, held until accepted
- `m0_writedata` / `m1_writedata`, in, `DATA_W`, write data
- `m0_waitrequest` / `m1_waitrequest`, out, 1, high = request not yet accepted
- `m0_readdata` / `m1_readdata`, out, `DATA_W`, registered read data
- `m0_readdatavalid` / `m1_readdatavalid`, out, 1, one-cycle pulse qualifying `readdata`
- `ram_address`, out, `ADDR_W`, RAM address
- `ram_byteenable`, out, `BE_W`, RAM byte enables
- `ram_chipselect`, out, 1, RAM select
- `ram_write`, out, 1, RAM write strobe
- `ram_writedata`, out, `DATA_W`, RAM write data
- `ram_readdata`, in, `DATA_W`, RAM read data, valid the cycle after the address cycle

## Operation
- The FSM has three states: IDLE, ISSUE, RDATA. A `grant` register (1 bit) holds the winner. A `last_grant` register (1 bit) holds the previous winner.
- A port requests when `read | write` is high. If both `read` and `write` are high, the access is treated as a write and the read is ignored.
- IDLE:
  - No request: stay in IDLE.
  - Otherwise, pick a winner, load `grant`, load `last_grant := grant`, and go to ISSUE.
  - Only one port requesting: that port wins.
  - Both ports requesting: arbitrate per Configuration.
- ISSUE (exactly one cycle):
  - Drive `ram_chipselect=1`.
  - Drive `ram_address`, `ram_byteenable`, `ram_writedata`, and `ram_write` from the granted port's live inputs, muxed combinationally. This is safe because masters hold their inputs stable while stalled.
  - Drop the granted port's `waitrequest` to 0. This is the accept cycle.
  - Next state is RDATA for a read, IDLE for a write.
- RDATA (one cycle):
  - Register `ram_readdata` into the granted port's `readdata`.
  - Set that port's `readdatavalid` flop, so it is high on the next cycle only.
  - Go to IDLE.
  - The other port's `readdata` holds its previous value.
- `mX_waitrequest` is 1 in every state except ISSUE with `grant==X`.
- RAM outputs are 0 outside ISSUE. `ram_chipselect` and `ram_write` are also gated by `reset_n`, so no RAM write can occur in a reset cycle.
- Reset (`reset_n` low at a clock edge):
  - FSM goes to IDLE; `grant=0`; `last_grant=1`; both `readdatavalid=0`; both `readdata=0`.
  - Any read in flight is dropped and no valid pulse is produced for it.
- Reset values of all outputs: `waitrequest` 1 on both ports, `readdatavalid` 0, `readdata` 0, `ram_*` 0.

## Timing
- Write: request seen in IDLE at cycle T, accepted at T+1. Minimum 2 cycles per write.
- Read: request seen at T, accepted at T+1, RAM data at T+2, `readdatavalid` high at T+3. Minimum 3 cycles per read.
- The next request can be sampled in the same cycle as a `readdatavalid` pulse, because the FSM is already in IDLE.
- A request that arrives while the FSM is in ISSUE or RDATA waits for the next IDLE.
- Worst-case stall for a continuously requesting port with round robin: one foreign access plus its own, at most 5 cycles.

## Configuration
- `RAM_ARB_ROUND_ROBIN_EN` defined:
  - On simultaneous requests, the winner is `~last_grant`.
  - Because `last_grant` resets to 1, port 0 wins the first tie.
- Not defined:
  - Fixed priority: port 0 always wins ties.
  - The `last_grant` register is not built.
  - Port 1 can be starved by back-to-back port 0 traffic.

## Test plan
- Reset: hold `reset_n` low for 3 cycles -> both `waitrequest`=1, `readdatavalid`=0, `ram_chipselect`=0, `readdata`=0.
- Single write then read: m0 writes 0xDEADBEEF with byteenable 0xF at address 0x3FF, then reads 0x3FF.
  - Required: write accepted 1 cycle after request.
  - Required: `m0_readdata`=0xDEADBEEF with `readdatavalid` 3 cycles after the read request.
  - Required: m1 outputs unchanged throughout.
- Byte lanes: write 0x11223344, then write 0xAABBCCDD with byteenable 0x5, then read -> 0x11BB33DD.
- Contention (with `RAM_ARB_ROUND_ROBIN_EN`): both ports read continuously, m0 at 0x001 and m1 at 0x002.
  - Required: grants alternate 0,1,0,1.
  - Required: each `readdatavalid` carries the correct port's data.
  - Without the macro: m1 is never granted while m0 keeps requesting.
- Reset mid-read: assert `reset_n` low in the RDATA cycle -> no `readdatavalid` pulse on either port, FSM returns to IDLE, `ram_write` stays 0.
- Read+write asserted together on m1 with address 0x010 and data 0x5A5A5A5A -> one write is performed, no `readdatavalid` pulse, and a later read of 0x010 returns 0x5A5A5A5A.
